// File: rtl/instruction_fetch.sv
// IF stage: instruction memory with a program write port feeding the IF/ID
// register, with post-reset warm-up bubbles, stall hold and flush squash.
module instruction_fetch #(
    parameter int bus_counter = 5,
    parameter int instr_width = 32,
    parameter int mem_depth   = 2 ** bus_counter,
    parameter int cnt_width   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [bus_counter-1:0] pc_in,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   prog_we,
    input  logic [bus_counter-1:0] prog_addr,
    input  logic [instr_width-1:0] prog_data,
    output logic                   pc_ena,
    output logic [instr_width-1:0] instr_out,
    output logic [bus_counter-1:0] pc_out,
    output logic                   valid_out,
    output logic [cnt_width-1:0]   fetch_cnt
);
    localparam int addr_w = (mem_depth > 1) ? $clog2(mem_depth) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [instr_width-1:0] mem_r [mem_depth];
    logic [instr_width-1:0] rd_data_s;
    logic                   rd_ok_s;
    logic                   wr_ok_s;
    logic [instr_width-1:0] instr_next_s;
    logic [bus_counter-1:0] pc_next_s;
    logic                   valid_next_s;
    logic                   load_valid_s;

    // Addresses beyond a shallow memory read as zero and drop writes
    if (mem_depth < 2 ** bus_counter) begin : g_partial
        assign rd_ok_s = (pc_in < bus_counter'(mem_depth));
        assign wr_ok_s = (prog_addr < bus_counter'(mem_depth));
    end else begin : g_full
        assign rd_ok_s = 1'b1;
        assign wr_ok_s = 1'b1;
    end

    // Program write port; active in every state, reset leaves contents alone
    always_ff @(posedge clk) begin
        if (prog_we && wr_ok_s) begin
            mem_r[prog_addr[addr_w-1:0]] <= prog_data;
        end
    end

    // Combinational read; a same-edge write is seen only on the next visit
    always_comb begin
        rd_data_s = '0;
        if (rd_ok_s) begin
            rd_data_s = mem_r[pc_in[addr_w-1:0]];
        end else begin
            rd_data_s = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state, PC enable and next IF/ID contents (flush > stall > normal)
    always_comb begin
        state_next_s = state_r;
        pc_ena       = 1'b1;
        instr_next_s = '0;
        pc_next_s    = pc_in;
        valid_next_s = 1'b0;
        load_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                state_next_s = WARM;
            end
            WARM: begin
                // Bubble swallows the all-ones value the PC holds after its reset
                state_next_s = RUN;
            end
            RUN: begin
                state_next_s = RUN;
                pc_ena       = !stall || flush;
                if (flush) begin
                    instr_next_s = '0;
                    pc_next_s    = pc_in;
                    valid_next_s = 1'b0;
                end else if (stall) begin
                    instr_next_s = instr_out;
                    pc_next_s    = pc_out;
                    valid_next_s = valid_out;
                end else begin
                    instr_next_s = rd_data_s;
                    pc_next_s    = pc_in;
                    valid_next_s = 1'b1;
                    load_valid_s = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_out <= '0;
            pc_out    <= '0;
            valid_out <= 1'b0;
        end else begin
            instr_out <= instr_next_s;
            pc_out    <= pc_next_s;
            valid_out <= valid_next_s;
        end
    end

    // Saturating count of valid instructions handed to decode
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
        end else if (load_valid_s && (fetch_cnt != '1)) begin
            fetch_cnt <= fetch_cnt + cnt_width'(1);
        end else begin
            fetch_cnt <= fetch_cnt;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a negedge PC model drives pc_in, and a
// second instance uses a 4-bit counter and a 16-word memory.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [31:0] prog_data;
    logic [4:0]  pc;
    logic [4:0]  jump_pc;
    logic        pc_rst;

    logic        pc_ena;
    logic [31:0] instr_out;
    logic [4:0]  pc_out;
    logic        valid_out;
    logic [15:0] fetch_cnt;

    logic        c4_pc_ena;
    logic [31:0] c4_instr;
    logic [4:0]  c4_pc;
    logic        c4_valid;
    logic [3:0]  c4_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .pc_in(pc), .stall(stall), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .pc_ena(pc_ena), .instr_out(instr_out), .pc_out(pc_out),
        .valid_out(valid_out), .fetch_cnt(fetch_cnt)
    );

    instruction_fetch #(.cnt_width(4), .mem_depth(16)) dut_c4 (
        .clk(clk), .rst(rst), .pc_in(pc), .stall(stall), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .pc_ena(c4_pc_ena), .instr_out(c4_instr), .pc_out(c4_pc),
        .valid_out(c4_valid), .fetch_cnt(c4_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: IF/ID captures at posedge, then the PC model steps at negedge.
    // The PC stays in reset one negedge past rst so all-ones meets the WARM bubble.
    task automatic tick();
        @(posedge clk);
        #1;
        @(negedge clk);
        if (pc_rst) pc = 5'h1F;
        else if (pc_ena) pc = flush ? jump_pc : pc + 5'd1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; prog_we = 1'b0;
        prog_addr = 5'd0; prog_data = 32'd0; pc_rst = 1'b1; pc = 5'h1F; jump_pc = 5'd0;

        for (int k = 0; k < 32; k++) begin
            prog_we = 1'b1; prog_addr = 5'(k); prog_data = 32'hA000_0000 + 32'(k);
            tick();
        end
        prog_we = 1'b0;
        tick();
        check("rst_instr", instr_out, 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_cnt", 32'(fetch_cnt), 32'd0);
        check("rst_pc_ena", 32'(pc_ena), 32'd1);
        check("c4_rst_cnt", 32'(c4_cnt), 32'd0);

        // Warm-up: two bubbles, then addresses 0..3
        rst = 1'b0;
        tick();
        check("idle_valid", 32'(valid_out), 32'd0);
        check("idle_instr", instr_out, 32'd0);
        check("idle_pc", 32'(pc_out), 32'd31);
        pc_rst = 1'b0;
        tick();
        check("warm_valid", 32'(valid_out), 32'd0);
        check("warm_pc", 32'(pc_out), 32'd31);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("run_instr", instr_out, 32'hA000_0000 + 32'(k));
            check("run_pc", 32'(pc_out), 32'(k));
            check("run_valid", 32'(valid_out), 32'd1);
        end
        check("cnt_4", 32'(fetch_cnt), 32'd4);
        check("c4_cnt_4", 32'(c4_cnt), 32'd4);

        // Stall three cycles holding address 3
        stall = 1'b1;
        #1;
        check("stall_pc_ena", 32'(pc_ena), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_instr", instr_out, 32'hA000_0003);
            check("stall_pc", 32'(pc_out), 32'd3);
            check("stall_valid", 32'(valid_out), 32'd1);
        end
        stall = 1'b0;
        tick();
        check("post_stall_instr", instr_out, 32'hA000_0004);
        check("post_stall_pc", 32'(pc_out), 32'd4);
        check("cnt_5", 32'(fetch_cnt), 32'd5);

        // Flush at pc=5 with a jump to 1
        flush = 1'b1; jump_pc = 5'd1;
        #1;
        check("flush_pc_ena", 32'(pc_ena), 32'd1);
        tick();
        check("flush_valid", 32'(valid_out), 32'd0);
        check("flush_instr", instr_out, 32'd0);
        check("flush_pc", 32'(pc_out), 32'd5);
        flush = 1'b0;
        tick();
        check("jump_instr", instr_out, 32'hA000_0001);
        check("jump_pc", 32'(pc_out), 32'd1);
        check("jump_valid", 32'(valid_out), 32'd1);

        // Flush and stall together at pc=2, jump to 6
        flush = 1'b1; stall = 1'b1; jump_pc = 5'd6;
        #1;
        check("fs_pc_ena", 32'(pc_ena), 32'd1);
        tick();
        check("fs_valid", 32'(valid_out), 32'd0);
        check("fs_instr", instr_out, 32'd0);
        flush = 1'b0; stall = 1'b0;
        tick();
        check("fs_next_instr", instr_out, 32'hA000_0006);
        check("fs_next_pc", 32'(pc_out), 32'd6);
        check("cnt_7", 32'(fetch_cnt), 32'd7);

        // Write the address being fetched: old word now, new word on revisit
        prog_we = 1'b1; prog_addr = 5'd7; prog_data = 32'hDEAD_BEEF;
        tick();
        prog_we = 1'b0;
        check("rbw_instr", instr_out, 32'hA000_0007);
        flush = 1'b1; jump_pc = 5'd7;
        tick();
        flush = 1'b0;
        check("revisit_bubble", 32'(valid_out), 32'd0);
        tick();
        check("revisit_instr", instr_out, 32'hDEAD_BEEF);
        check("revisit_pc", 32'(pc_out), 32'd7);
        check("cnt_9", 32'(fetch_cnt), 32'd9);

        // One-cycle reset mid-run
        rst = 1'b1; pc_rst = 1'b1;
        tick();
        check("mrst_instr", instr_out, 32'd0);
        check("mrst_pc", 32'(pc_out), 32'd0);
        check("mrst_valid", 32'(valid_out), 32'd0);
        check("mrst_cnt", 32'(fetch_cnt), 32'd0);
        check("mrst_c4_cnt", 32'(c4_cnt), 32'd0);
        check("mrst_pc_ena", 32'(pc_ena), 32'd1);
        rst = 1'b0;
        tick();
        check("mrst_idle_valid", 32'(valid_out), 32'd0);
        pc_rst = 1'b0;
        tick();
        check("mrst_warm_valid", 32'(valid_out), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("refetch_instr", instr_out, (k == 7) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(k));
            check("refetch_pc", 32'(pc_out), 32'(k));
        end
        check("cnt_8", 32'(fetch_cnt), 32'd8);

        // Run through PC wrap; small instance saturates and reads zero past depth 16
        for (int i = 8; i < 34; i++) begin
            tick();
            check("wrap_instr", instr_out, 32'hA000_0000 + 32'(i % 32));
            check("c4_instr", c4_instr, ((i % 32) < 16) ? 32'hA000_0000 + 32'(i % 32) : 32'd0);
            check("c4_valid", 32'(c4_valid), 32'd1);
        end
        check("wrap_pc", 32'(pc_out), 32'd1);
        check("cnt_34", 32'(fetch_cnt), 32'd34);
        check("c4_cnt_sat", 32'(c4_cnt), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
